// File: rtl/mem_bus_arbiter.sv
// Two-master bus arbiter: instruction fetch and data access share one bus,
// with a bounded data-grant streak and a per-transaction ack timeout.
module mem_bus_arbiter #(
   parameter int unsigned MEM_STREAK_MAX = 4,
   parameter int unsigned TIMEOUT        = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [3:0]  mem_sel,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ack,
   output logic        stallreq_if,
   output logic        stallreq_mem,
   output logic        bus_cyc,
   output logic        bus_stb,
   output logic        bus_we,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        bus_err
);

   localparam int unsigned SW = $clog2(MEM_STREAK_MAX + 1);

   typedef enum logic [1:0] {IDLE, BUS_IF, BUS_MEM} state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] streak;
   logic [7:0]    to_cnt;
   logic          grant_if, grant_mem, done, abort;

   assign stallreq_if  = if_req & ~if_ack;
   assign stallreq_mem = mem_req & ~mem_ack;

   always_comb begin
      state_nxt = state;
      grant_if  = 1'b0;
      grant_mem = 1'b0;
      done      = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (mem_req && !(if_req && streak == SW'(MEM_STREAK_MAX))) begin
               grant_mem = 1'b1;
               state_nxt = BUS_MEM;
            end else if (if_req) begin
               grant_if  = 1'b1;
               state_nxt = BUS_IF;
            end
         end
         BUS_IF, BUS_MEM: begin
            // an ack arriving on the final timeout cycle still wins
            if (bus_ack)
               done = 1'b1;
            else if (to_cnt == 8'(TIMEOUT - 1))
               abort = 1'b1;
            if (done || abort)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         streak    <= '0;
         to_cnt    <= '0;
         bus_cyc   <= 1'b0;
         bus_stb   <= 1'b0;
         bus_we    <= 1'b0;
         bus_sel   <= '0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_err   <= 1'b0;
         if_ack    <= 1'b0;
         if_rdata  <= '0;
         mem_ack   <= 1'b0;
         mem_rdata <= '0;
      end else begin
         if_ack  <= 1'b0;
         mem_ack <= 1'b0;
         bus_err <= 1'b0;
         if (grant_mem) begin
            bus_addr  <= mem_addr;
            bus_we    <= mem_we;
            bus_sel   <= mem_sel;
            bus_wdata <= mem_wdata;
            bus_cyc   <= 1'b1;
            bus_stb   <= 1'b1;
            to_cnt    <= '0;
            // grant rule keeps streak below the cap whenever if_req is set
            streak    <= if_req ? streak + SW'(1) : '0;
         end
         if (grant_if) begin
            bus_addr  <= if_addr;
            bus_we    <= 1'b0;
            bus_sel   <= '1;
            bus_wdata <= '0;
            bus_cyc   <= 1'b1;
            bus_stb   <= 1'b1;
            to_cnt    <= '0;
            streak    <= '0;
         end
         if (state != IDLE) begin
            if (done || abort) begin
               bus_cyc <= 1'b0;
               bus_stb <= 1'b0;
               bus_we  <= 1'b0;
               bus_err <= abort;
               if (state == BUS_IF) begin
                  if_ack   <= 1'b1;
                  if_rdata <= done ? bus_rdata : '0;
               end else begin
                  mem_ack   <= 1'b1;
                  mem_rdata <= (done && !bus_we) ? bus_rdata : '0;
               end
            end else begin
               to_cnt <= to_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single-master transaction table plus
// arbitration, timeout, idle-ack and reset sequences.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, mem_req, mem_we, bus_ack;
   logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
   logic [3:0]  mem_sel;
   logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
   logic        if_ack, mem_ack, stallreq_if, stallreq_mem;
   logic        bus_cyc, bus_stb, bus_we, bus_err;
   logic [3:0]  bus_sel;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.MEM_STREAK_MAX(4), .TIMEOUT(255)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
      .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_sel(bus_sel),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_ack(bus_ack), .bus_err(bus_err)
   );

   typedef struct {
      bit          is_if;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int unsigned delay;
      logic        exp_we;
      logic [3:0]  exp_sel;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      if (v.is_if) begin
         if_req = 1'b1; if_addr = v.addr;
      end else begin
         mem_req = 1'b1; mem_addr = v.addr; mem_we = v.we;
         mem_sel = v.sel; mem_wdata = v.wdata;
      end
      #1;
      chk("stall_c0", v.is_if ? stallreq_if : stallreq_mem, 1);
      tick();
      chk("cyc_c1", bus_cyc, 1);
      chk("stb_c1", bus_stb, 1);
      chk("addr_c1", bus_addr, v.addr);
      chk("we_c1", bus_we, v.exp_we);
      chk("sel_c1", bus_sel, v.exp_sel);
      chk("wdata_c1", bus_wdata, v.exp_wdata);
      if_addr = ~if_addr; mem_addr = ~mem_addr; mem_we = ~mem_we;
      mem_sel = ~mem_sel; mem_wdata = ~mem_wdata;
      for (int d = 0; d < int'(v.delay); d++) begin
         tick();
         chk("addr_hold", bus_addr, v.addr);
         chk("we_hold", bus_we, v.exp_we);
         chk("stb_hold", bus_stb, 1);
      end
      bus_ack = 1'b1; bus_rdata = v.rdata;
      #1;
      chk("stall_ackcyc", v.is_if ? stallreq_if : stallreq_mem, 1);
      tick();
      bus_ack = 1'b0; bus_rdata = $urandom;
      chk("x_ack", v.is_if ? if_ack : mem_ack, 1);
      chk("other_ack", v.is_if ? mem_ack : if_ack, 0);
      chk("x_rdata", v.is_if ? if_rdata : mem_rdata, v.exp_rdata);
      chk("cyc_done", bus_cyc, 0);
      chk("stall_done", v.is_if ? stallreq_if : stallreq_mem, 0);
      chk("err_done", bus_err, 0);
      if_req = 1'b0; mem_req = 1'b0;
      tick();
      chk("x_ack_pulse", v.is_if ? if_ack : mem_ack, 0);
      chk("x_rdata_hold", v.is_if ? if_rdata : mem_rdata, v.exp_rdata);
      chk("cyc_idle", bus_cyc, 0);
   endtask

   initial begin
      string       order;
      int unsigned got, n;
      bit          early;

      vecs[0] = '{0, 32'h100, 1, 4'hF, 32'hDEADBEEF, 32'h13579BDF, 2, 1, 4'hF, 32'hDEADBEEF, 32'h0};
      vecs[1] = '{1, 32'h4, 0, 4'h0, 32'h0, 32'h24020001, 0, 0, 4'hF, 32'h0, 32'h24020001};
      vecs[2] = '{0, 32'h200, 0, 4'h3, 32'hCAFEF00D, 32'h12345678, 1, 0, 4'h3, 32'hCAFEF00D, 32'h12345678};
      vecs[3] = '{0, 32'hFFFFFFFC, 1, 4'h4, 32'hA5A5A5A5, 32'h11111111, 0, 1, 4'h4, 32'hA5A5A5A5, 32'h0};
      vecs[4] = '{1, 32'h80000000, 0, 4'h0, 32'h0, 32'hFFFFFFFF, 3, 0, 4'hF, 32'h0, 32'hFFFFFFFF};

      rst = 1'b0;
      if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_sel = 0;
      mem_addr = 0; mem_wdata = 0; bus_rdata = 0; bus_ack = 0;
      tick();
      tick();
      chk("rst_cyc", bus_cyc, 0);
      chk("rst_stb", bus_stb, 0);
      chk("rst_addr", bus_addr, 0);
      chk("rst_acks", {if_ack, mem_ack, bus_err}, 0);
      chk("rst_rdata", if_rdata | mem_rdata, 0);
      #2 rst = 1'b1;
      tick();

      // stray ack while idle
      bus_ack = 1'b1; bus_rdata = 32'h99999999;
      tick();
      tick();
      chk("idle_ack_cyc", bus_cyc, 0);
      chk("idle_ack_acks", {if_ack, mem_ack, bus_err}, 0);
      chk("idle_ack_rdata", mem_rdata, 0);
      bus_ack = 1'b0;

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // both requesters held, bus acks every cycle
      if_addr = 32'hAAAA0000; mem_addr = 32'hBBBB0000; mem_we = 0; mem_sel = 4'hF;
      if_req = 1; mem_req = 1; bus_ack = 1; bus_rdata = 32'h5555AAAA;
      order = "";
      got = 0;
      for (int c = 0; c < 40 && got < 10; c++) begin
         tick();
         if (bus_stb) begin
            order = {order, (bus_addr == 32'hAAAA0000) ? "I" : "M"};
            got++;
         end
      end
      if_req = 0; mem_req = 0;
      tick();
      bus_ack = 0;
      tick();
      checks++;
      if (order != "MMMMIMMMMI") begin
         failures++;
         $display("FAIL grant_order actual=%s required=MMMMIMMMMI", order);
      end
      chk("arb_idle", bus_cyc, 0);

      // no ack at all: abort after 255 bus cycles
      mem_req = 1; mem_we = 0; mem_addr = 32'h300; mem_sel = 4'hF;
      tick();
      n = 0; early = 0;
      while (bus_stb && n < 300) begin
         if (bus_err) early = 1;
         n++;
         tick();
      end
      chk("to_cycles", n, 255);
      chk("to_early_err", early, 0);
      chk("to_err", bus_err, 1);
      chk("to_ack", mem_ack, 1);
      chk("to_rdata", mem_rdata, 0);
      chk("to_cyc", bus_cyc, 0);
      mem_req = 0;
      tick();
      chk("to_err_pulse", bus_err, 0);
      chk("to_idle", bus_stb, 0);

      // ack exactly on the last permitted cycle
      mem_req = 1; mem_addr = 32'h304;
      tick();
      for (int c = 1; c < 255; c++) tick();
      chk("late_stb", bus_stb, 1);
      bus_ack = 1; bus_rdata = 32'h0BADF00D;
      tick();
      bus_ack = 0; mem_req = 0;
      chk("late_ack", mem_ack, 1);
      chk("late_err", bus_err, 0);
      chk("late_rdata", mem_rdata, 32'h0BADF00D);

      // requester drops mid-transaction
      tick();
      mem_req = 1; mem_addr = 32'h308;
      tick();
      mem_req = 0;
      tick();
      chk("drop_stb", bus_stb, 1);
      bus_ack = 1; bus_rdata = 32'h00000077;
      tick();
      bus_ack = 0;
      chk("drop_ack", mem_ack, 1);
      chk("drop_rdata", mem_rdata, 32'h00000077);

      // reset during an active fetch, fetch still requested afterwards
      tick();
      if_req = 1; if_addr = 32'h40;
      tick();
      chk("mid_stb", bus_stb, 1);
      rst = 0;
      #1;
      chk("mid_rst_cyc", bus_cyc, 0);
      chk("mid_rst_stb", bus_stb, 0);
      chk("mid_rst_acks", {if_ack, mem_ack}, 0);
      chk("mid_rst_rdata", mem_rdata, 0);
      #2 rst = 1;
      tick();
      chk("regrant_stb", bus_stb, 1);
      chk("regrant_addr", bus_addr, 32'h40);
      bus_ack = 1; bus_rdata = 32'hFEEDFACE;
      tick();
      bus_ack = 0; if_req = 0;
      chk("regrant_ack", if_ack, 1);
      chk("regrant_rdata", if_rdata, 32'hFEEDFACE);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter MEM_STREAK_MAX, default 4: max consecutive data grants while fetch waits.
REQ-002 SHALL have parameter TIMEOUT, default 255: bus cycles without ack before abort (8-bit counter).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port if_req  in  1  fetch request, held until if_ack.
REQ-006 SHALL have port if_addr  in  32  fetch word address.
REQ-007 SHALL have port if_rdata  out  32  fetch read data, valid with if_ack.
REQ-008 SHALL have port if_ack  out  1  one-cycle fetch completion pulse.
REQ-009 SHALL have port mem_req  in  1  data request, held until mem_ack.
REQ-010 SHALL have port mem_we  in  1  data write enable.
REQ-011 SHALL have port mem_sel  in  4  data byte lanes.
REQ-012 SHALL have port mem_addr / mem_wdata  in  32 each  data address / write data.
REQ-013 SHALL have port mem_rdata  out  32  data read data, valid with mem_ack.
REQ-014 SHALL have port mem_ack  out  1  one-cycle data completion pulse.
REQ-015 SHALL have ports stallreq_if, stallreq_mem  out  1 each  pipeline stall requests.
REQ-016 SHALL have ports bus_cyc, bus_stb, bus_we  out  1 each; bus_sel out 4; bus_addr, bus_wdata out 32.
REQ-017 SHALL have ports bus_rdata  in  32, bus_ack  in  1  bus completion.
REQ-018 SHALL have port bus_err  out  1  one-cycle timeout-abort pulse.

Function
REQ-019 SHALL implement FSM states IDLE, BUS_IF, BUS_MEM; one transaction at a time.
REQ-020 In IDLE, mem_req alone or with if_req (streak < MEM_STREAK_MAX) SHALL go to BUS_MEM; if_req alone or streak == MEM_STREAK_MAX with if_req SHALL go to BUS_IF; no request stays IDLE.
REQ-021 Streak counter SHALL increment on each BUS_MEM grant made while if_req=1, clear on any BUS_IF grant or on a BUS_MEM grant with if_req=0, saturate at MEM_STREAK_MAX.
REQ-022 On grant, bus_addr/bus_we/bus_sel/bus_wdata SHALL register the winner's inputs; bus_cyc=bus_stb=1 from the next cycle; BUS_IF drives bus_we=0, bus_sel=4'b1111.
REQ-023 Bus outputs SHALL stay constant while in a BUS state regardless of requester input changes.
REQ-024 On bus_ack=1 in BUS_x: next cycle x_ack=1 for one cycle, x_rdata=registered bus_rdata (write: 0), bus_cyc/bus_stb=0, FSM to IDLE.
REQ-025 Minimum latency: request in IDLE at cycle 0 -> bus_stb cycle 1 -> ack earliest cycle 1 -> x_ack cycle 2; one IDLE cycle between transactions.
REQ-026 x_rdata SHALL hold its value until the next x_ack.
REQ-027 stallreq_if SHALL equal if_req & ~if_ack; stallreq_mem SHALL equal mem_req & ~mem_ack (combinational).
REQ-028 Timeout counter SHALL clear on entering a BUS state and increment each BUS cycle without bus_ack; on reaching TIMEOUT: drop bus_cyc/bus_stb, pulse bus_err and x_ack with x_rdata=0, return to IDLE.
REQ-029 bus_ack and timeout in the same cycle SHALL be treated as ack; no bus_err.
REQ-030 Requester deasserting req mid-transaction SHALL NOT abort the bus cycle; x_ack still pulses.
REQ-031 bus_ack in IDLE SHALL be ignored.

Reset
REQ-032 rst=0 SHALL immediately force IDLE, streak=0, timeout=0, all outputs 0, including mid-transaction.
REQ-033 First grant SHALL be evaluated on the first rising clk edge after rst returns to 1.

Verification
REQ-034 mem_req write addr 0x100 wdata 0xDEADBEEF sel 0xF, bus_ack on cycle 3 -> bus_we=1 cycles 1-3, mem_ack cycle 4, stallreq_mem 1 cycles 0-3.
REQ-035 if_req and mem_req held continuously, ack each 1 cycle -> grant order MEM x4, IF, MEM x4, IF.
REQ-036 if_req addr 0x4, bus_rdata 0x24020001 with ack -> if_rdata=0x24020001, if_ack one cycle.
REQ-037 mem_req read, bus_ack never -> bus_err and mem_ack pulse after 255 BUS cycles, mem_rdata=0, FSM IDLE.
REQ-038 bus_ack on the 255th BUS cycle -> normal completion, bus_err=0.
REQ-039 rst low while bus_stb=1 -> bus_cyc, bus_stb, acks 0 same cycle; after release, held if_req regranted.
